// File: rtl/x_alp_sim_exit_monitor_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : x_alp_sim_exit_monitor_pkg
//  Purpose  : Shared types and constants for the simulation exit monitor:
//             FSM state encoding, register word offsets, default base
//             address and watchdog exit code, and the STATUS word packer.
//  Revision : 1.0  initial release
// ============================================================================
package x_alp_sim_exit_monitor_pkg;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        DONE = 1'b1
    } exit_mon_state_e;

    // Word offsets inside the 16-byte window (addr[3:2])
    localparam logic [1:0]  c_word_exit   = 2'd0;
    localparam logic [1:0]  c_word_putc   = 2'd1;
    localparam logic [1:0]  c_word_status = 2'd2;

    localparam logic [31:0] c_exit_mon_base         = 32'h0300_0000;
    localparam logic [31:0] c_exit_mon_timeout_code = 32'h0000_DEAD;

    // STATUS layout: {fifo count, 13'b0, fifo full, finished, exit valid}
    function automatic logic [31:0] status_word(input logic [15:0] count,
                                                input logic        full,
                                                input logic        done,
                                                input logic        exit_valid);
        return {count, 13'd0, full, done, exit_valid};
    endfunction

endpackage
`default_nettype wire

// File: rtl/x_alp_sim_exit_monitor_if.sv
`default_nettype none
// ============================================================================
//  Module   : x_alp_sim_exit_monitor_if
//  Purpose  : Bus port (req/gnt/rvalid) plus console character stream
//             (valid/ready) of the simulation exit monitor.
//  Modports : master - bus initiator and character sink (testbench / SoC)
//             slave  - the exit monitor itself
//  Revision : 1.0  initial release
// ============================================================================
interface x_alp_sim_exit_monitor_if #(
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                  req_i;
    logic                  we_i;
    logic [ADDR_WIDTH-1:0] addr_i;
    logic [3:0]            be_i;
    logic [31:0]           wdata_i;
    logic                  gnt_o;
    logic                  rvalid_o;
    logic [31:0]           rdata_o;
    logic                  char_valid_o;
    logic [7:0]            char_data_o;
    logic                  char_ready_i;

    modport master (
        output req_i, we_i, addr_i, be_i, wdata_i, char_ready_i,
        input  gnt_o, rvalid_o, rdata_o, char_valid_o, char_data_o
    );

    modport slave (
        input  req_i, we_i, addr_i, be_i, wdata_i, char_ready_i,
        output gnt_o, rvalid_o, rdata_o, char_valid_o, char_data_o
    );
endinterface
`default_nettype wire

// File: rtl/x_alp_sim_char_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : x_alp_sim_char_fifo
//  Purpose  : First-word fall-through FIFO for console characters.
//  Ports    : clk, rst (async, active-high)
//             i_push/i_push_data - write side, ignored when full
//             i_pop              - read side, ignored when empty
//             o_valid/o_head     - head entry, valid while not empty
//             o_full/o_empty/o_count - occupancy
//  Revision : 1.0  initial release
// ============================================================================
module x_alp_sim_char_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    input  wire logic                     i_push,
    input  wire logic [WIDTH-1:0]         i_push_data,
    input  wire logic                     i_pop,
    output logic                          o_valid,
    output logic [WIDTH-1:0]              o_head,
    output logic                          o_full,
    output logic                          o_empty,
    output logic [$clog2(DEPTH):0]        o_count
);
    localparam int unsigned c_ptr_w = $clog2(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_count;
    logic               w_push;
    logic               w_pop;

    assign o_full  = (r_count == (c_ptr_w + 1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_valid = ~o_empty;
    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    assign w_push = i_push & ~o_full;
    assign w_pop  = i_pop & ~o_empty;

    // Storage needs no reset: entries are only observable once counted
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_ptr_w + 1)'(1);
                2'b01:   r_count <= r_count - (c_ptr_w + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/x_alp_sim_exit_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : x_alp_sim_exit_monitor
//  Purpose  : Simulation bus target that turns software writes into a
//             testharness exit code, buffers console characters and
//             forces an exit when a cycle watchdog expires.
//  Ports    : clk_i, rst_i (async, active-high)
//             bus          - slave side of bus + character stream
//             exit_valid_o - sticky "simulation finished"
//             exit_value_o - exit code (1 until finished)
//  Window   : BASE_ADDR+0 EXIT, +4 PUTC, +8 STATUS, +12 reserved
//  Revision : 1.0  initial release
// ============================================================================
module x_alp_sim_exit_monitor
    import x_alp_sim_exit_monitor_pkg::*;
#(
    parameter int unsigned          ADDR_WIDTH     = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR     = ADDR_WIDTH'(c_exit_mon_base),
    parameter int unsigned          FIFO_DEPTH     = 16,
    parameter logic [31:0]          TIMEOUT_CYCLES = 32'd0,
    parameter logic [31:0]          TIMEOUT_CODE   = c_exit_mon_timeout_code
) (
    input  wire logic               clk_i,
    input  wire logic               rst_i,
    x_alp_sim_exit_monitor_if.slave bus,
    output logic                    exit_valid_o,
    output logic [31:0]             exit_value_o
);
    localparam int unsigned c_cnt_w = $clog2(FIFO_DEPTH) + 1;

    exit_mon_state_e    r_state;
    logic               r_exit_valid;
    logic [31:0]        r_exit_value;
    logic [31:0]        r_wd_count;
    logic               r_rvalid;
    logic [31:0]        r_rdata;

    logic               w_hit;
    logic [1:0]         w_word;
    logic               w_is_exit;
    logic               w_is_putc;
    logic               w_is_status;
    logic               w_gnt;
    logic               w_wr;
    logic               w_rd;
    logic               w_push;
    logic               w_pop;
    logic               w_exit_wr;
    logic               w_wd_expire;
    logic [31:0]        w_rdata;
    logic               w_fifo_valid;
    logic [7:0]         w_fifo_head;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic [c_cnt_w-1:0] w_fifo_count;
    logic               w_unused_addr_bits;

    // ---------------------------------------------------------------- decode
    assign w_hit       = (bus.addr_i[ADDR_WIDTH-1:4] == BASE_ADDR[ADDR_WIDTH-1:4]);
    assign w_word      = bus.addr_i[3:2];
    assign w_is_exit   = w_hit & (w_word == c_word_exit);
    assign w_is_putc   = w_hit & (w_word == c_word_putc);
    assign w_is_status = w_hit & (w_word == c_word_status);
    assign w_unused_addr_bits = ^bus.addr_i[1:0];

    // Only a PUTC write into a full FIFO stalls; a pop in the same cycle
    // does not help because the full flag is registered state.
    assign w_gnt     = ~rst_i & bus.req_i & ~(bus.we_i & w_is_putc & w_fifo_full);
    assign bus.gnt_o = w_gnt;

    assign w_wr   = w_gnt & bus.we_i;
    assign w_rd   = w_gnt & ~bus.we_i;
    assign w_push = w_wr & w_is_putc & bus.be_i[0];
    assign w_pop  = w_fifo_valid & bus.char_ready_i;

    assign w_exit_wr = w_wr & w_is_exit & (bus.be_i == 4'hF) & bus.wdata_i[0]
                     & (r_state == RUN);

    assign w_wd_expire = (TIMEOUT_CYCLES != 32'd0) && (r_state == RUN)
                      && (r_wd_count == TIMEOUT_CYCLES - 32'd1);

    always_comb begin
        w_rdata = '0;
        if (w_is_status) begin
            w_rdata = status_word(16'(w_fifo_count), w_fifo_full,
                                  (r_state == DONE), r_exit_valid);
        end
    end

    // -------------------------------------------------------- response path
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= w_gnt;
            r_rdata  <= w_rd ? w_rdata : 32'd0;
        end
    end

    assign bus.rvalid_o = r_rvalid;
    assign bus.rdata_o  = r_rdata;

    // ------------------------------------------------ exit FSM + watchdog
    // A software exit write takes priority over a watchdog expiry in the
    // same cycle so the program's own code is what gets reported.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= RUN;
            r_exit_valid <= 1'b0;
            r_exit_value <= 32'd1;
            r_wd_count   <= '0;
        end else begin
            case (r_state)
                RUN: begin
                    if (r_wd_count != '1) begin
                        r_wd_count <= r_wd_count + 32'd1;
                    end
                    if (w_exit_wr) begin
                        r_state      <= DONE;
                        r_exit_valid <= 1'b1;
                        r_exit_value <= {1'b0, bus.wdata_i[31:1]};
                    end else if (w_wd_expire) begin
                        r_state      <= DONE;
                        r_exit_valid <= 1'b1;
                        r_exit_value <= TIMEOUT_CODE;
                    end
                end
                DONE: begin
                    r_state <= DONE;
                end
                default: begin
                    r_state <= RUN;
                end
            endcase
        end
    end

    assign exit_valid_o = r_exit_valid;
    assign exit_value_o = r_exit_value;

    // ------------------------------------------------------- console FIFO
    x_alp_sim_char_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_char_fifo (
        .clk         (clk_i),
        .rst         (rst_i),
        .i_push      (w_push),
        .i_push_data (bus.wdata_i[7:0]),
        .i_pop       (w_pop),
        .o_valid     (w_fifo_valid),
        .o_head      (w_fifo_head),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty),
        .o_count     (w_fifo_count)
    );

    assign bus.char_valid_o = w_fifo_valid;
    assign bus.char_data_o  = w_fifo_head;

endmodule
`default_nettype wire

// File: tb/tb_x_alp_sim_exit_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_x_alp_sim_exit_monitor
//  Purpose  : Self-checking bench for x_alp_sim_exit_monitor. Stimulus
//             pushes expected read data and console characters into
//             queues; monitors pop and compare when the DUT presents
//             rvalid or a character handshake.
//  Revision : 1.0  initial release
// ============================================================================
module tb_x_alp_sim_exit_monitor;
    import x_alp_sim_exit_monitor_pkg::*;

    localparam logic [31:0] c_base     = 32'h0300_0000;
    localparam logic [31:0] c_a_exit   = c_base;
    localparam logic [31:0] c_a_putc   = c_base + 32'd4;
    localparam logic [31:0] c_a_status = c_base + 32'd8;
    localparam logic [31:0] c_a_rsvd   = c_base + 32'd12;
    localparam logic [31:0] c_a_outwin = 32'h0400_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        rst_wd;
    logic        exit_valid;
    logic [31:0] exit_value;
    logic        exit_valid_wd;
    logic [31:0] exit_value_wd;

    always #5 clk = ~clk;

    x_alp_sim_exit_monitor_if #(.ADDR_WIDTH(32)) bus ();
    x_alp_sim_exit_monitor_if #(.ADDR_WIDTH(32)) bus_wd ();

    x_alp_sim_exit_monitor #(
        .ADDR_WIDTH     (32),
        .BASE_ADDR      (c_base),
        .FIFO_DEPTH     (16),
        .TIMEOUT_CYCLES (32'd0),
        .TIMEOUT_CODE   (32'hDEAD)
    ) u_dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .bus          (bus),
        .exit_valid_o (exit_valid),
        .exit_value_o (exit_value)
    );

    x_alp_sim_exit_monitor #(
        .ADDR_WIDTH     (32),
        .BASE_ADDR      (c_base),
        .FIFO_DEPTH     (16),
        .TIMEOUT_CYCLES (32'd100),
        .TIMEOUT_CODE   (32'hDEAD)
    ) u_dut_wd (
        .clk_i        (clk),
        .rst_i        (rst_wd),
        .bus          (bus_wd),
        .exit_valid_o (exit_valid_wd),
        .exit_value_o (exit_value_wd)
    );

    int          n_total = 0;
    int          n_pass  = 0;
    logic [31:0] rd_exp[$];
    logic [7:0]  ch_exp[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    endtask

    task automatic fail(input string name);
        n_total++;
        $display("FAIL %s: event did not occur as expected", name);
    endtask

    // ------------------------------------------------------------ monitors
    always @(negedge clk) begin
        if (bus.rvalid_o) begin
            if (rd_exp.size() == 0) fail("rvalid_unexpected");
            else check("rdata", bus.rdata_o, rd_exp.pop_front());
        end
        if (bus.char_valid_o && bus.char_ready_i) begin
            if (ch_exp.size() == 0) fail("char_unexpected");
            else check("char_data", 32'(bus.char_data_o), 32'(ch_exp.pop_front()));
        end
    end

    // Called just after a rising edge; returns just after the edge that
    // completes the grant.
    task automatic bus_xfer(input logic we, input logic [31:0] addr, input logic [3:0] be,
                            input logic [31:0] wdata, input logic [31:0] exp_rdata);
        int waited;
        bus.req_i   = 1'b1;
        bus.we_i    = we;
        bus.addr_i  = addr;
        bus.be_i    = be;
        bus.wdata_i = wdata;
        @(negedge clk);
        check("gnt_same_cycle", 32'(bus.gnt_o), 32'd1);
        waited = 0;
        while (!bus.gnt_o && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (bus.gnt_o) rd_exp.push_back(we ? 32'd0 : exp_rdata);
        else fail("gnt_timeout");
        @(posedge clk); #1;
        bus.req_i = 1'b0;
    endtask

    task automatic drain_chars(input int budget);
        bus.char_ready_i = 1'b1;
        for (int i = 0; i < budget; i++) begin
            if (!bus.char_valid_o) break;
            @(posedge clk); #1;
        end
        check("fifo_drained", 32'(bus.char_valid_o), 32'd0);
        bus.char_ready_i = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // ------------------------------------------------------------ stimulus
    initial begin
        bus.req_i = 1'b0; bus.we_i = 1'b0; bus.addr_i = '0; bus.be_i = '0;
        bus.wdata_i = '0; bus.char_ready_i = 1'b0;
        bus_wd.req_i = 1'b0; bus_wd.we_i = 1'b0; bus_wd.addr_i = '0; bus_wd.be_i = '0;
        bus_wd.wdata_i = '0; bus_wd.char_ready_i = 1'b0;
        rst = 1'b1;
        rst_wd = 1'b1;

        // Reset state, and no grant while reset is held
        repeat (2) @(posedge clk);
        #1;
        bus.req_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = c_a_status; bus.be_i = 4'hF;
        #1;
        check("gnt_in_reset", 32'(bus.gnt_o), 32'd0);
        check("rst_exit_valid", 32'(exit_valid), 32'd0);
        check("rst_exit_value", exit_value, 32'd1);
        check("rst_char_valid", 32'(bus.char_valid_o), 32'd0);
        check("rst_rvalid", 32'(bus.rvalid_o), 32'd0);
        bus.req_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Rejected EXIT writes: bit0 clear, partial byte enables
        bus_xfer(1'b1, c_a_exit, 4'hF, 32'h0000_0054, 32'd0);
        check("exit_bit0_clear", 32'(exit_valid), 32'd0);
        bus_xfer(1'b1, c_a_exit, 4'h3, 32'h0000_0055, 32'd0);
        check("exit_partial_be", 32'(exit_valid), 32'd0);
        bus_xfer(1'b0, c_a_status, 4'hF, 32'd0, 32'h0000_0000);

        // Accepted EXIT write, then a second one is ignored
        bus_xfer(1'b1, c_a_exit, 4'hF, 32'h0000_0055, 32'd0);
        check("exit_valid_set", 32'(exit_valid), 32'd1);
        check("exit_value_2a", exit_value, 32'h0000_002A);
        bus_xfer(1'b0, c_a_status, 4'hF, 32'd0, 32'h0000_0003);
        bus_xfer(1'b1, c_a_exit, 4'hF, 32'h0000_0007, 32'd0);
        check("exit_value_sticky", exit_value, 32'h0000_002A);

        // Non-status reads all return zero
        bus_xfer(1'b0, c_a_exit,   4'hF, 32'd0, 32'd0);
        bus_xfer(1'b0, c_a_putc,   4'hF, 32'd0, 32'd0);
        bus_xfer(1'b0, c_a_rsvd,   4'hF, 32'd0, 32'd0);
        bus_xfer(1'b0, c_a_outwin, 4'hF, 32'd0, 32'd0);

        // Console characters; be[0]=0 write is dropped
        bus_xfer(1'b1, c_a_putc, 4'h1, 32'h0000_0048, 32'd0);
        bus_xfer(1'b1, c_a_putc, 4'hF, 32'hABCD_EF69, 32'd0);
        bus_xfer(1'b1, c_a_putc, 4'hE, 32'h0000_0021, 32'd0);
        check("char_valid_head", 32'(bus.char_valid_o), 32'd1);
        check("char_head_h", 32'(bus.char_data_o), 32'h48);
        bus_xfer(1'b0, c_a_status, 4'hF, 32'd0, 32'h0002_0003);
        ch_exp.push_back(8'h48);
        ch_exp.push_back(8'h69);
        drain_chars(10);

        // Fill to full, then a stalled 17th PUTC
        for (int i = 0; i < 16; i++) begin
            bus_xfer(1'b1, c_a_putc, 4'h1, 32'h41 + 32'(i), 32'd0);
            ch_exp.push_back(8'(8'h41 + i));
        end
        bus_xfer(1'b0, c_a_status, 4'hF, 32'd0, 32'h0010_0007);
        bus.req_i = 1'b1; bus.we_i = 1'b1; bus.addr_i = c_a_putc; bus.be_i = 4'h1;
        bus.wdata_i = 32'h0000_005A;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("gnt_full_stall", 32'(bus.gnt_o), 32'd0);
            @(posedge clk); #1;
        end
        bus.char_ready_i = 1'b1;
        @(negedge clk);
        check("gnt_full_pop_same_cycle", 32'(bus.gnt_o), 32'd0);
        @(posedge clk); #1;
        bus.char_ready_i = 1'b0;
        @(negedge clk);
        check("gnt_after_pop", 32'(bus.gnt_o), 32'd1);
        if (bus.gnt_o) begin
            rd_exp.push_back(32'd0);
            ch_exp.push_back(8'h5A);
        end
        @(posedge clk); #1;
        bus.req_i = 1'b0;
        drain_chars(40);

        // Reset mid-operation with a response in flight and chars buffered
        bus_xfer(1'b1, c_a_putc, 4'h1, 32'h0000_0078, 32'd0);
        bus_xfer(1'b1, c_a_putc, 4'h1, 32'h0000_0079, 32'd0);
        bus.req_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = c_a_status; bus.be_i = 4'hF;
        @(posedge clk); #1;
        bus.req_i = 1'b0;
        check("rvalid_before_reset", 32'(bus.rvalid_o), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        rd_exp.delete();
        check("midrst_rvalid", 32'(bus.rvalid_o), 32'd0);
        check("midrst_exit_valid", 32'(exit_valid), 32'd0);
        check("midrst_exit_value", exit_value, 32'd1);
        check("midrst_char_valid", 32'(bus.char_valid_o), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        bus_xfer(1'b0, c_a_status, 4'hF, 32'd0, 32'h0000_0000);
        bus_xfer(1'b1, c_a_exit, 4'hF, 32'h0000_0003, 32'd0);
        check("exit_after_reset", 32'(exit_valid), 32'd1);
        check("exit_value_after_reset", exit_value, 32'd1);

        // Watchdog: 100 cycles after reset release
        @(posedge clk); #1;
        rst_wd = 1'b0;
        repeat (99) @(posedge clk);
        #1;
        check("wd_not_yet", 32'(exit_valid_wd), 32'd0);
        @(posedge clk); #1;
        check("wd_expired", 32'(exit_valid_wd), 32'd1);
        check("wd_code", exit_value_wd, 32'h0000_DEAD);

        // Watchdog expiry coinciding with a software EXIT write
        rst_wd = 1'b1;
        #2;
        check("wd_rst_exit_valid", 32'(exit_valid_wd), 32'd0);
        @(posedge clk); #1;
        rst_wd = 1'b0;
        repeat (99) @(posedge clk);
        #1;
        bus_wd.req_i = 1'b1; bus_wd.we_i = 1'b1; bus_wd.addr_i = c_a_exit;
        bus_wd.be_i = 4'hF; bus_wd.wdata_i = 32'h0000_0011;
        @(negedge clk);
        check("wd_gnt_exit", 32'(bus_wd.gnt_o), 32'd1);
        @(posedge clk); #1;
        bus_wd.req_i = 1'b0;
        check("wd_vs_write_valid", 32'(exit_valid_wd), 32'd1);
        check("wd_vs_write_code", exit_value_wd, 32'h0000_0008);

        repeat (3) @(posedge clk);
        #1;
        check("rd_queue_empty", 32'(rd_exp.size()), 32'd0);
        check("ch_queue_empty", 32'(ch_exp.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
